micro_address_gen: RTL and testbench

- Fetch/sequencer stage directly upstream of the 7-bit-address, 13-bit-word microcode decode ROM.
- Holds the program counter, the instruction register, the C/Z flag register and the fetch/execute phase flip-flop.
- Assembles the ROM address as {opcode[3:0], C, Z, phase}.
- Consumes the PC-control bits that the decode ROM drives back, which closes the fetch/execute loop.

---
 rtl/micro_address_gen.sv | 79 +++++++
 tb/tb_micro_address_gen.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/micro_address_gen.sv
// Fetch/execute sequencer feeding the microcode decode ROM: holds PC, instruction
// register, C/Z flags and the phase flip-flop, and forms the ROM address from them.
module micro_address_gen #(
    parameter int PC_WIDTH    = 12,
    parameter int INSTR_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [INSTR_WIDTH-1:0] program_byte,
    input  logic                   inc_pc,
    input  logic                   load_pc,
    input  logic [PC_WIDTH-1:0]    load_addr,
    input  logic                   flags_we,
    input  logic                   c_in,
    input  logic                   z_in,
    output logic [PC_WIDTH-1:0]    pc,
    output logic [6:0]             direccion,
    output logic [3:0]             operand,
    output logic                   phase,
    output logic                   c_flag,
    output logic                   z_flag
);

    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } state_t;

    state_t                 state;
    state_t                 nextstate;
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]    pcnext;

    // Phase strictly alternates on every enabled edge; stalls come only from enable.
    always_comb begin
        nextstate = state;
        if (enable) begin
            nextstate = (state == FETCH) ? EXEC : FETCH;
        end
    end

    // A jump outranks a simultaneous increment; the increment wraps naturally.
    always_comb begin
        pcnext = pc;
        if (enable) begin
            if (load_pc) begin
                pcnext = load_addr;
            end else if (inc_pc) begin
                pcnext = pc + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= FETCH;
            pc     <= '0;
            instr  <= '0;
            c_flag <= 1'b0;
            z_flag <= 1'b0;
        end else begin
            state <= nextstate;
            pc    <= pcnext;
            if (enable && state == FETCH) begin
                instr <= program_byte;
            end
            if (enable && flags_we) begin
                c_flag <= c_in;
                z_flag <= z_in;
            end
        end
    end

    assign phase     = (state == EXEC);
    assign operand   = instr[3:0];
    assign direccion = {instr[INSTR_WIDTH-1 -: 4], c_flag, z_flag, phase};

endmodule

// File: tb/tb_micro_address_gen.sv
// Self-checking bench for micro_address_gen: directed vector table, a mid-cycle
// reset sequence and randomized traffic checked against an arithmetic model.
module tb_micro_address_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [7:0]  program_byte;
    logic        inc_pc;
    logic        load_pc;
    logic [11:0] load_addr;
    logic        flags_we;
    logic        c_in;
    logic        z_in;
    logic [11:0] pc;
    logic [6:0]  direccion;
    logic [3:0]  operand;
    logic        phase;
    logic        c_flag;
    logic        z_flag;

    int checks = 0;
    int errors = 0;

    // Reference model state: plain integers updated from the sequencing rules.
    int mpc;
    int minstr;
    int mphase;
    int mc;
    int mz;

    micro_address_gen #(.PC_WIDTH(12), .INSTR_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .program_byte(program_byte),
        .inc_pc(inc_pc), .load_pc(load_pc), .load_addr(load_addr),
        .flags_we(flags_we), .c_in(c_in), .z_in(z_in), .pc(pc),
        .direccion(direccion), .operand(operand), .phase(phase),
        .c_flag(c_flag), .z_flag(z_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [7:0]  pb;
        logic        inc;
        logic        ld;
        logic [11:0] la;
        logic        fwe;
        logic        c;
        logic        z;
        logic [11:0] exppc;
        logic [6:0]  expdir;
        logic [3:0]  expop;
        logic        expphase;
    } vec_t;

    vec_t vecs[14];

    task automatic compareField(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        mpc = 0; minstr = 0; mphase = 0; mc = 0; mz = 0;
    endtask

    // Drives one cycle of inputs, takes the rising edge, and advances the model.
    task automatic applyStimulus(input logic en, input logic [7:0] pb, input logic inc,
                                 input logic ld, input logic [11:0] la, input logic fwe,
                                 input logic c, input logic z);
        enable = en; program_byte = pb; inc_pc = inc; load_pc = ld;
        load_addr = la; flags_we = fwe; c_in = c; z_in = z;
        @(posedge clk);
        if (en) begin
            if (ld) mpc = int'(la);
            else if (inc) mpc = (mpc + 1) % 4096;
            if (mphase == 0) minstr = int'(pb);
            mphase = 1 - mphase;
            if (fwe) begin
                mc = int'(c);
                mz = int'(z);
            end
        end
        #1;
    endtask

    task automatic checkOutput(input string tag);
        int expdir;
        expdir = (minstr / 16) * 8 + mc * 4 + mz * 2 + mphase;
        compareField({tag, " pc"}, 32'(pc), 32'(mpc));
        compareField({tag, " direccion"}, 32'(direccion), 32'(expdir));
        compareField({tag, " operand"}, 32'(operand), 32'(minstr % 16));
        compareField({tag, " phase"}, 32'(phase), 32'(mphase));
        compareField({tag, " c_flag"}, 32'(c_flag), 32'(mc));
        compareField({tag, " z_flag"}, 32'(z_flag), 32'(mz));
    endtask

    initial begin
        //         en  pb     inc ld  la       fwe c  z    pc       dir          op    ph
        vecs[0]  = '{1, 8'h5A, 1, 0, 12'h000, 0, 0, 0, 12'h001, 7'b0101001, 4'hA, 1};
        vecs[1]  = '{1, 8'h00, 0, 0, 12'h000, 0, 0, 0, 12'h001, 7'b0101000, 4'hA, 0};
        vecs[2]  = '{1, 8'hC3, 1, 0, 12'h000, 0, 0, 0, 12'h002, 7'b1100001, 4'h3, 1};
        vecs[3]  = '{1, 8'h11, 1, 1, 12'h3C7, 1, 1, 0, 12'h3C7, 7'b1100100, 4'h3, 0};
        vecs[4]  = '{1, 8'hC0, 0, 0, 12'h000, 0, 0, 1, 12'h3C7, 7'b1100101, 4'h0, 1};
        vecs[5]  = '{1, 8'h22, 0, 1, 12'hFFF, 1, 0, 1, 12'hFFF, 7'b1100010, 4'h0, 0};
        vecs[6]  = '{1, 8'hC5, 1, 0, 12'h000, 0, 1, 1, 12'h000, 7'b1100011, 4'h5, 1};
        vecs[7]  = '{1, 8'h77, 1, 0, 12'h000, 0, 0, 0, 12'h001, 7'b1100010, 4'h5, 0};
        vecs[8]  = '{0, 8'hFF, 1, 1, 12'h123, 1, 1, 0, 12'h001, 7'b1100010, 4'h5, 0};
        vecs[9]  = '{0, 8'h0F, 0, 1, 12'hABC, 0, 1, 1, 12'h001, 7'b1100010, 4'h5, 0};
        vecs[10] = '{0, 8'hF0, 1, 0, 12'h456, 1, 0, 0, 12'h001, 7'b1100010, 4'h5, 0};
        vecs[11] = '{0, 8'h99, 1, 1, 12'hFFF, 1, 1, 1, 12'h001, 7'b1100010, 4'h5, 0};
        vecs[12] = '{0, 8'h66, 0, 0, 12'h000, 1, 0, 1, 12'h001, 7'b1100010, 4'h5, 0};
        vecs[13] = '{1, 8'h3E, 0, 0, 12'h000, 0, 0, 0, 12'h001, 7'b0011011, 4'hE, 1};

        reset = 1'b1;
        enable = 1'b0; program_byte = '0; inc_pc = 0; load_pc = 0;
        load_addr = '0; flags_we = 0; c_in = 0; z_in = 0;
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset");
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].en, vecs[i].pb, vecs[i].inc, vecs[i].ld,
                          vecs[i].la, vecs[i].fwe, vecs[i].c, vecs[i].z);
            compareField($sformatf("vec%0d pc", i), 32'(pc), 32'(vecs[i].exppc));
            compareField($sformatf("vec%0d direccion", i), 32'(direccion), 32'(vecs[i].expdir));
            compareField($sformatf("vec%0d operand", i), 32'(operand), 32'(vecs[i].expop));
            compareField($sformatf("vec%0d phase", i), 32'(phase), 32'(vecs[i].expphase));
            checkOutput($sformatf("vec%0d model", i));
        end

        // Mid-instruction asynchronous reset with phase=1, pc=0x020, c_flag=1.
        applyStimulus(1, 8'h00, 0, 1, 12'h020, 1, 1, 0);
        applyStimulus(1, 8'h7B, 0, 0, 12'h000, 0, 0, 0);
        compareField("pre-reset phase", 32'(phase), 32'd1);
        compareField("pre-reset pc", 32'(pc), 32'h020);
        compareField("pre-reset c_flag", 32'(c_flag), 32'd1);
        #2 reset = 1'b1;
        #1;
        modelReset();
        compareField("async pc", 32'(pc), 32'd0);
        compareField("async direccion", 32'(direccion), 32'd0);
        compareField("async operand", 32'(operand), 32'd0);
        compareField("async phase", 32'(phase), 32'd0);
        compareField("async flags", 32'({c_flag, z_flag}), 32'd0);
        #1 reset = 1'b0;
        applyStimulus(1, 8'h91, 1, 0, 12'h000, 0, 0, 0);
        compareField("post-reset fetch direccion", 32'(direccion), 32'b1001001);
        compareField("post-reset fetch pc", 32'(pc), 32'd1);
        checkOutput("post-reset");

        // Randomized traffic, with an occasional asynchronous reset between edges.
        for (int n = 0; n < 400; n++) begin
            applyStimulus(($urandom_range(0, 3) != 0), 8'($urandom),
                          1'($urandom), ($urandom_range(0, 5) == 0),
                          (($urandom_range(0, 1) == 0) ? 12'hFFF : 12'($urandom)),
                          1'($urandom), 1'($urandom), 1'($urandom));
            checkOutput($sformatf("rand%0d", n));
            if ($urandom_range(0, 49) == 0) begin
                #2 reset = 1'b1;
                #1;
                modelReset();
                checkOutput($sformatf("rand%0d reset", n));
                #1 reset = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
